// File: rtl/irq_capture16.sv
// 16-source rising-edge interrupt capture with a present/ack/holdoff handshake (Valid one edge after Pend).
// Optional IRQ_SYNC_EN macro inserts a 2-flop synchroniser per Irq bit (+2 cycles latency).
module irq_capture16 #(
   parameter int HOLDOFF = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] Irq,
   input  logic [15:0] Mask,
   output logic [15:0] Pend,
   output logic        Valid,
   input  logic        Ack,
   input  logic [3:0]  AckIdx,
   output logic        Ovf
);

   typedef enum logic [1:0] {IDLE, PRESENT, HOLD} state_t;

   localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF - 1);

   state_t      state, state_nxt;
   logic [15:0] samp, prev, pending, pending_nxt, rise, clr;
   logic [3:0]  cnt, cnt_nxt;
   logic        ovf_nxt;

`ifdef IRQ_SYNC_EN
   logic [15:0] sync1, sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= Irq;
         sync2 <= sync1;
      end
   end

   assign samp = sync2;
`else
   assign samp = Irq;
`endif

   assign Pend  = pending & ~Mask;
   assign Valid = (state == PRESENT);

   // A new edge on the bit being acknowledged wins over the clear and is not an overflow.
   always_comb begin
      rise = samp & ~prev;
      clr  = '0;
      if (state == PRESENT && Ack)
         clr = 16'h0001 << AckIdx;
      pending_nxt = (pending & ~clr) | rise;
      ovf_nxt     = |(rise & pending & ~clr);
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (Pend != 16'h0000)
               state_nxt = PRESENT;
         end
         PRESENT: begin
            if (Ack) begin
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LOAD;
            end else if (Pend == 16'h0000) begin
               state_nxt = IDLE;
            end
         end
         HOLD: begin
            if (cnt == 4'd0)
               state_nxt = IDLE;
            else
               cnt_nxt = cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         prev    <= '0;
         pending <= '0;
         Ovf     <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         prev    <= samp;
         pending <= pending_nxt;
         Ovf     <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_irq_capture16.sv
// Directed bench for irq_capture16: vector table for the handshake, plus hand sequences for reset and sync latency.
module tb_irq_capture16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] Irq, Mask, Pend;
   logic        Valid, Ack, Ovf;
   logic [3:0]  AckIdx;

   int checks = 0;
   int failures = 0;

   irq_capture16 #(.HOLDOFF(2)) dut (
      .clk(clk), .rst_n(rst_n), .Irq(Irq), .Mask(Mask), .Pend(Pend),
      .Valid(Valid), .Ack(Ack), .AckIdx(AckIdx), .Ovf(Ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] irq;
      logic [15:0] mask;
      logic        ack;
      logic [3:0]  idx;
      logic [15:0] pend;
      logic        valid;
      logic        ovf;
   } vec_t;

   vec_t vq[$];

   function automatic void add(logic [15:0] irq, logic [15:0] mask, logic ack, logic [3:0] idx,
                               logic [15:0] pend, logic valid, logic ovf);
      vec_t v;
      v.irq = irq; v.mask = mask; v.ack = ack; v.idx = idx;
      v.pend = pend; v.valid = valid; v.ovf = ovf;
      vq.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] p, input logic v, input logic o);
      chk({tag, " pend"}, Pend, p);
      chk({tag, " valid"}, {15'd0, Valid}, {15'd0, v});
      chk({tag, " ovf"}, {15'd0, Ovf}, {15'd0, o});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; Irq = '0; Mask = '0; Ack = 1'b0; AckIdx = '0;
      repeat (2) step();
      chk_all("reset", 16'h0000, 1'b0, 1'b0);
      rst_n = 1'b1;

`ifndef IRQ_SYNC_EN
      // single source, ack, holdoff of 2
      add(16'h0004, 16'h0, 0, 0,  16'h0004, 0, 0);
      add(16'h0004, 16'h0, 0, 0,  16'h0004, 1, 0);
      add(16'h0004, 16'h0, 1, 2,  16'h0000, 0, 0);
      add(16'h0000, 16'h0, 0, 0,  16'h0000, 0, 0);
      add(16'h0000, 16'h0, 0, 0,  16'h0000, 0, 0);
      add(16'h0000, 16'h0, 0, 0,  16'h0000, 0, 0);
      // two sources, service 15 then re-present 0
      add(16'h8001, 16'h0, 0, 0,  16'h8001, 0, 0);
      add(16'h8001, 16'h0, 0, 0,  16'h8001, 1, 0);
      add(16'h8001, 16'h0, 1, 15, 16'h0001, 0, 0);
      add(16'h8001, 16'h0, 0, 0,  16'h0001, 0, 0);
      add(16'h8001, 16'h0, 0, 0,  16'h0001, 0, 0);
      add(16'h8001, 16'h0, 0, 0,  16'h0001, 1, 0);
      add(16'h8001, 16'h0, 1, 0,  16'h0000, 0, 0);
      add(16'h0000, 16'h0, 0, 0,  16'h0000, 0, 0);
      add(16'h0000, 16'h0, 0, 0,  16'h0000, 0, 0);
      // mask after presentation, then unmask
      add(16'h0010, 16'h0000, 0, 0, 16'h0010, 0, 0);
      add(16'h0010, 16'h0000, 0, 0, 16'h0010, 1, 0);
      add(16'h0010, 16'h0010, 0, 0, 16'h0000, 0, 0);
      add(16'h0010, 16'h0010, 0, 0, 16'h0000, 0, 0);
      add(16'h0010, 16'h0000, 0, 0, 16'h0010, 1, 0);
      add(16'h0000, 16'h0000, 1, 4, 16'h0000, 0, 0);
      add(16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0);
      add(16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0);
      // overflow on re-pulse of a pending source
      add(16'h0008, 16'h0, 0, 0,  16'h0008, 0, 0);
      add(16'h0000, 16'h0, 0, 0,  16'h0008, 1, 0);
      add(16'h0008, 16'h0, 0, 0,  16'h0008, 1, 1);
      add(16'h0008, 16'h0, 0, 0,  16'h0008, 1, 0);
      add(16'h0000, 16'h0, 0, 0,  16'h0008, 1, 0);
      // set and clear of the same bit: set wins, no overflow
      add(16'h0008, 16'h0, 1, 3,  16'h0008, 0, 0);
      // ack in HOLD and IDLE is ignored
      add(16'h0008, 16'h0, 1, 3,  16'h0008, 0, 0);
      add(16'h0008, 16'h0, 1, 3,  16'h0008, 0, 0);
      add(16'h0008, 16'h0, 1, 3,  16'h0008, 1, 0);
      // ack of a non-pending index still enters HOLD
      add(16'h0008, 16'h0, 1, 5,  16'h0008, 0, 0);
      add(16'h0008, 16'h0, 0, 0,  16'h0008, 0, 0);
      add(16'h0008, 16'h0, 0, 0,  16'h0008, 0, 0);
      add(16'h0008, 16'h0, 0, 0,  16'h0008, 1, 0);
      add(16'h0000, 16'h0, 1, 3,  16'h0000, 0, 0);
      add(16'h0000, 16'h0, 0, 0,  16'h0000, 0, 0);
      add(16'h0000, 16'h0, 0, 0,  16'h0000, 0, 0);
      // eight sources for the reset-mid-handshake sequence
      add(16'h00FF, 16'h0, 0, 0,  16'h00FF, 0, 0);
      add(16'h00FF, 16'h0, 0, 0,  16'h00FF, 1, 0);

      for (int i = 0; i < vq.size(); i++) begin
         Irq = vq[i].irq; Mask = vq[i].mask; Ack = vq[i].ack; AckIdx = vq[i].idx;
         step();
         chk_all($sformatf("vec%0d", i), vq[i].pend, vq[i].valid, vq[i].ovf);
      end

      // asynchronous reset while Valid is high, then a source held high across release
      Ack = 1'b0; AckIdx = '0;
      #2;
      Irq = 16'h0001;
      rst_n = 1'b0;
      #1;
      chk_all("rst_async", 16'h0000, 1'b0, 1'b0);
      #1;
      rst_n = 1'b1;
      step();
      chk_all("rst_rel1", 16'h0001, 1'b0, 1'b0);
      step();
      chk_all("rst_rel2", 16'h0001, 1'b1, 1'b0);
`else
      // synchronised path: capture two edges later than the direct path
      Irq = 16'h0100;
      step();
      chk_all("sync_e1", 16'h0000, 1'b0, 1'b0);
      step();
      chk_all("sync_e2", 16'h0000, 1'b0, 1'b0);
      step();
      chk_all("sync_e3", 16'h0100, 1'b0, 1'b0);
      step();
      chk_all("sync_e4", 16'h0100, 1'b1, 1'b0);
      Ack = 1'b1; AckIdx = 4'd8;
      step();
      chk_all("sync_ack", 16'h0000, 1'b0, 1'b0);
      Irq = 16'h0000;
      step();
      chk_all("sync_hold", 16'h0000, 1'b0, 1'b0);
      step();
      chk_all("sync_idle", 16'h0000, 1'b0, 1'b0);
      Ack = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
